activation_arbiter: RTL and testbench
=====================================

Name: activation_arbiter

Overview:
- Shares one activation unit among N requesters (neurons in a layer); the unit is valid/ready on argument, activation, feedback and delta.
- Round-robin grants one requester per transaction and holds the grant for the full exchange: argument→activation, plus feedback→delta when training.
- Sits between the neuron array and the single activation instance; owns all sequencing of that instance.

Parameters:
- N, 4, number of requesters (2..16).
- ARG_W, 16, argument/feedback/delta width.
- ACT_W, 8, activation width.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- train  in  1  training mode, sampled at grant.
- req_argument_valid  in  N  per-requester argument valid.
- req_argument_data  in  N*ARG_W  packed arguments; requester i at [i*ARG_W +: ARG_W].
- req_argument_ready  out  N  per-requester argument ready.
- req_activation_valid  out  N  activation valid, granted requester only.
- req_activation_data  out  ACT_W  activation, broadcast.
- req_activation_ready  in  N  per-requester activation ready.
- req_feedback_valid  in  N  feedback valid.
- req_feedback_data  in  N*ARG_W  packed feedback.
- req_feedback_ready  out  N  feedback ready.
- req_delta_valid  out  N  delta valid, granted requester only.
- req_delta_data  out  ARG_W  delta, broadcast.
- req_delta_ready  in  N  delta ready.
- unit_argument_valid/data/ready  out/out/in  1/ARG_W/1  argument channel to the shared unit.
- unit_activation_valid/data/ready  in/in/out  1/ACT_W/1  activation channel from the unit.
- unit_feedback_valid/data/ready  out/out/in  1/ARG_W/1  feedback channel to the unit.
- unit_delta_valid/data/ready  in/in/out  1/ARG_W/1  delta channel from the unit.
- grant  out  N  one-hot current owner; 0 when idle.
- busy  out  1  transaction in progress.

Behaviour:
- States: IDLE, ARG, ACT, FBK, DEL (registered). Reset: state=IDLE, grant=0, priority pointer=0, train_q=0, busy=0. Every valid/ready output is 0 during and after reset until a grant exists.
- IDLE: if any req_argument_valid, pick the first asserted index scanning from the pointer upward with wrap (pointer, pointer+1, …, N-1, 0, …). Next cycle: grant=one-hot(winner), train_q=train, state=ARG, busy=1. A request must be visible for 1 cycle before its ready can rise; grant-to-first-handshake latency is 1 cycle.
- ARG: unit_argument_valid=req_argument_valid[g]; unit_argument_data=slice g; req_argument_ready[g]=unit_argument_ready. All other req ready outputs are 0. On the unit argument handshake, go to ACT.
- ACT: req_activation_valid[g]=unit_activation_valid; unit_activation_ready=req_activation_ready[g]; data passes through. On handshake, go to FBK if train_q, else release.
- FBK: unit_feedback_valid/data come from requester g; ready is returned to g only. On handshake, go to DEL.
- DEL: req_delta_valid[g]=unit_delta_valid; unit_delta_ready=req_delta_ready[g]. On handshake, release.
- Release, registered on the final handshake edge: state=IDLE, grant=0, busy=0, pointer=(g+1) mod N. A new grant follows no earlier than the next cycle.
- Outside the matching state, each unit-side valid/ready is 0. The arbiter holds no data registers: all payload is combinational passthrough.
- train changes mid-transaction are ignored; train_q governs the whole transaction.
- Requester dropping argument_valid before its handshake: the grant is held and there is no timeout.
- Reset mid-transaction returns to IDLE with grant cleared. The shared unit must share the same reset.
- Requests not granted are never acked. No request may be starved: worst-case wait is N-1 transactions.

Test Plan:
- Single request, train=0, N=4: req 2 presents 0x0005 → grant=4'b0100 a cycle later; unit receives 0x0005; activation 0xFF reaches req 2 only; release; pointer=3.
- All four requesting continuously, train=0 → grant order 0,1,2,3,0; no requester is acked twice before all others are served.
- train=1, req 1 argument 0xFFF0, feedback 0x1234 → activation 0x00 to req 1; feedback_ready reaches req 1 only; unit delta 0x1234 goes to req 1 with req_delta_valid=4'b0010; then IDLE.
- train toggles 1→0 during the ACT state of a training transaction → the FBK and DEL states still occur; the next transaction runs without training.
- Backpressure: req 0 holds activation_ready=0 for 5 cycles → unit_activation_ready stays 0, data stays stable, grant is held; the handshake completes on the first ready cycle.
- Reset asserted in FBK → the next cycle has grant=0, busy=0 and all valids 0; a fresh request from req 3 is then granted with the pointer at 0 (scan 0..3).

Source files
------------

// File: rtl/activation_arbiter.sv
// Round-robin arbiter that lends one shared activation unit to N requesters and
// sequences the argument/activation and, when training, feedback/delta exchanges.
module activation_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned ARG_W = 16,
  parameter int unsigned ACT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 train,
  input  logic [N-1:0]         req_argument_valid,
  input  logic [N*ARG_W-1:0]   req_argument_data,
  output logic [N-1:0]         req_argument_ready,
  output logic [N-1:0]         req_activation_valid,
  output logic [ACT_W-1:0]     req_activation_data,
  input  logic [N-1:0]         req_activation_ready,
  input  logic [N-1:0]         req_feedback_valid,
  input  logic [N*ARG_W-1:0]   req_feedback_data,
  output logic [N-1:0]         req_feedback_ready,
  output logic [N-1:0]         req_delta_valid,
  output logic [ARG_W-1:0]     req_delta_data,
  input  logic [N-1:0]         req_delta_ready,
  output logic                 unit_argument_valid,
  output logic [ARG_W-1:0]     unit_argument_data,
  input  logic                 unit_argument_ready,
  input  logic                 unit_activation_valid,
  input  logic [ACT_W-1:0]     unit_activation_data,
  output logic                 unit_activation_ready,
  output logic                 unit_feedback_valid,
  output logic [ARG_W-1:0]     unit_feedback_data,
  input  logic                 unit_feedback_ready,
  input  logic                 unit_delta_valid,
  input  logic [ARG_W-1:0]     unit_delta_data,
  output logic                 unit_delta_ready,
  output logic [N-1:0]         grant,
  output logic                 busy
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW:0]  NCnt    = (IdxW + 1)'(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [N-1:0]   OneHot0 = {{(N - 1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StArg, StAct, StFbk, StDel} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] r_idx;
  logic            r_train;
  logic            r_busy;

  logic            w_found;
  logic [IdxW-1:0] w_winner;
  logic [IdxW:0]   w_cand;
  logic [IdxW-1:0] w_next_ptr;
  logic            w_arg_hs, w_act_hs, w_fbk_hs, w_del_hs;

  // First asserted request scanning upward from the pointer, wrapping at N.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_cand = {1'b0, r_ptr} + (IdxW + 1)'(i);
      if (w_cand >= NCnt) w_cand = w_cand - NCnt;
      if (!w_found && req_argument_valid[w_cand[IdxW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IdxW-1:0];
      end
    end
  end

  assign w_next_ptr = (r_idx == LastIdx) ? '0 : r_idx + IdxW'(1);

  // Pure passthrough steering; nothing is visible outside the owning state or in reset.
  always_comb begin
    req_argument_ready    = '0;
    req_activation_valid  = '0;
    req_feedback_ready    = '0;
    req_delta_valid       = '0;
    unit_argument_valid   = 1'b0;
    unit_activation_ready = 1'b0;
    unit_feedback_valid   = 1'b0;
    unit_delta_ready      = 1'b0;
    unit_argument_data    = req_argument_data[r_idx*ARG_W +: ARG_W];
    unit_feedback_data    = req_feedback_data[r_idx*ARG_W +: ARG_W];
    req_activation_data   = unit_activation_data;
    req_delta_data        = unit_delta_data;
    if (!reset) begin
      unique case (r_state)
        StArg: begin
          unit_argument_valid       = req_argument_valid[r_idx];
          req_argument_ready[r_idx] = unit_argument_ready;
        end
        StAct: begin
          req_activation_valid[r_idx] = unit_activation_valid;
          unit_activation_ready       = req_activation_ready[r_idx];
        end
        StFbk: begin
          unit_feedback_valid       = req_feedback_valid[r_idx];
          req_feedback_ready[r_idx] = unit_feedback_ready;
        end
        StDel: begin
          req_delta_valid[r_idx] = unit_delta_valid;
          unit_delta_ready       = req_delta_ready[r_idx];
        end
        default: ;
      endcase
    end
  end

  assign w_arg_hs = unit_argument_valid && unit_argument_ready;
  assign w_act_hs = unit_activation_valid && unit_activation_ready;
  assign w_fbk_hs = unit_feedback_valid && unit_feedback_ready;
  assign w_del_hs = unit_delta_valid && unit_delta_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_train <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state <= StArg;
            r_grant <= OneHot0 << w_winner;
            r_idx   <= w_winner;
            r_train <= train;
            r_busy  <= 1'b1;
          end
        end
        StArg: if (w_arg_hs) r_state <= StAct;
        StAct: begin
          if (w_act_hs) begin
            if (r_train) begin
              r_state <= StFbk;
            end else begin
              r_state <= StIdle;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_ptr   <= w_next_ptr;
            end
          end
        end
        StFbk: if (w_fbk_hs) r_state <= StDel;
        StDel: begin
          if (w_del_hs) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

// File: tb/tb_activation_arbiter.sv
// Directed bench: stimulus queues expected handshakes, a negedge monitor pops and checks them.
module tb_activation_arbiter;
  localparam int N = 4;
  localparam int ARG_W = 16;
  localparam int ACT_W = 8;
  localparam int KArg = 0, KAct = 1, KFbk = 2, KDel = 3;

  logic clock, reset, train;
  logic [N-1:0]       req_argument_valid, req_argument_ready;
  logic [N*ARG_W-1:0] req_argument_data;
  logic [N-1:0]       req_activation_valid, req_activation_ready;
  logic [ACT_W-1:0]   req_activation_data;
  logic [N-1:0]       req_feedback_valid, req_feedback_ready;
  logic [N*ARG_W-1:0] req_feedback_data;
  logic [N-1:0]       req_delta_valid, req_delta_ready;
  logic [ARG_W-1:0]   req_delta_data;
  logic               unit_argument_valid, unit_argument_ready;
  logic [ARG_W-1:0]   unit_argument_data;
  logic               unit_activation_valid, unit_activation_ready;
  logic [ACT_W-1:0]   unit_activation_data;
  logic               unit_feedback_valid, unit_feedback_ready;
  logic [ARG_W-1:0]   unit_feedback_data;
  logic               unit_delta_valid, unit_delta_ready;
  logic [ARG_W-1:0]   unit_delta_data;
  logic [N-1:0]       grant;
  logic               busy;

  activation_arbiter #(.N(N), .ARG_W(ARG_W), .ACT_W(ACT_W)) dut (
    .clock(clock), .reset(reset), .train(train),
    .req_argument_valid(req_argument_valid), .req_argument_data(req_argument_data),
    .req_argument_ready(req_argument_ready),
    .req_activation_valid(req_activation_valid), .req_activation_data(req_activation_data),
    .req_activation_ready(req_activation_ready),
    .req_feedback_valid(req_feedback_valid), .req_feedback_data(req_feedback_data),
    .req_feedback_ready(req_feedback_ready),
    .req_delta_valid(req_delta_valid), .req_delta_data(req_delta_data),
    .req_delta_ready(req_delta_ready),
    .unit_argument_valid(unit_argument_valid), .unit_argument_data(unit_argument_data),
    .unit_argument_ready(unit_argument_ready),
    .unit_activation_valid(unit_activation_valid), .unit_activation_data(unit_activation_data),
    .unit_activation_ready(unit_activation_ready),
    .unit_feedback_valid(unit_feedback_valid), .unit_feedback_data(unit_feedback_data),
    .unit_feedback_ready(unit_feedback_ready),
    .unit_delta_valid(unit_delta_valid), .unit_delta_data(unit_delta_data),
    .unit_delta_ready(unit_delta_ready),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    int           kind;
    logic [N-1:0] vec;
    logic [15:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_hs(input int kind, input int g, input logic [15:0] d);
    exp_t e;
    e.kind = kind;
    e.vec  = 4'b0001 << g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [N-1:0] vec, input logic [15:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_hs: kind %0d vec 0x%0h data 0x%0h at %0t", kind, vec, d, $time);
    end else begin
      e = exp_q.pop_front();
      chk("hs_kind", kind, e.kind);
      chk("hs_vec", 32'(vec), 32'(e.vec));
      chk("hs_data", 32'(d), 32'(e.data));
      if (kind == KArg) chk("hs_grant", 32'(grant), 32'(e.vec));
    end
  endtask

  // Monitor: every handshake must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (unit_argument_valid && unit_argument_ready)
          observe(KArg, req_argument_ready, unit_argument_data);
        if ((req_activation_valid & req_activation_ready) != 0)
          observe(KAct, req_activation_valid, {8'h00, req_activation_data});
        if (unit_feedback_valid && unit_feedback_ready)
          observe(KFbk, req_feedback_ready, unit_feedback_data);
        if ((req_delta_valid & req_delta_ready) != 0)
          observe(KDel, req_delta_valid, req_delta_data);
      end
    end
  end

  task automatic set_arg(input int i, input logic [15:0] v);
    req_argument_data[i*ARG_W +: ARG_W] = v;
  endtask

  function automatic logic [31:0] all_hs();
    return 32'({req_argument_ready, req_activation_valid, req_feedback_ready, req_delta_valid,
                unit_argument_valid, unit_activation_ready, unit_feedback_valid,
                unit_delta_ready});
  endfunction

  // Requesters drop argument_valid once their activation arrives (all at once when holding).
  task automatic run_txns(input bit hold, input int n_stop);
    int acts;
    bit done;
    logic [N-1:0] ahs;
    acts = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clock);
      ahs = req_activation_valid & req_activation_ready;
      @(posedge clock);
      #1;
      if (ahs != 0) begin
        acts++;
        if (!hold) req_argument_valid = req_argument_valid & ~ahs;
        else if (acts == n_stop) req_argument_valid = '0;
      end
      done = (exp_q.size() == 0) && !busy;
    end
    if (!done) begin
      n_total++;
      $display("FAIL run_timeout: %0d expectations left, busy %0b", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; train = 1'b0;
    req_argument_valid = '0; req_argument_data = '0;
    req_activation_ready = '1; req_feedback_valid = '1; req_delta_ready = '1;
    for (int i = 0; i < N; i++) req_feedback_data[i*ARG_W +: ARG_W] = 16'hA000 + 16'(i);
    req_feedback_data[1*ARG_W +: ARG_W] = 16'h1234;
    unit_argument_ready = 1'b1; unit_activation_valid = 1'b1; unit_activation_data = '0;
    unit_feedback_ready = 1'b1; unit_delta_valid = 1'b1; unit_delta_data = '0;

    @(negedge clock);
    chk("in_reset_hs", all_hs(), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_grant", 32'(grant), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_hs", all_hs(), 0);

    // All four requesting continuously: 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_arg(i, 16'h0100 + 16'(i));
    unit_activation_data = 8'h42;
    for (int k = 0; k < 5; k++) begin
      expect_hs(KArg, k % N, 16'h0100 + 16'(k % N));
      expect_hs(KAct, k % N, 16'h0042);
    end
    @(posedge clock); #1 req_argument_valid = '1;
    run_txns(1'b1, 5);

    // Single request from req 2, pointer now 1.
    set_arg(2, 16'h0005);
    unit_activation_data = 8'hFF;
    expect_hs(KArg, 2, 16'h0005);
    expect_hs(KAct, 2, 16'h00FF);
    req_argument_valid = 4'b0100;
    @(negedge clock);
    chk("pre_grant", 32'(grant), 0);
    chk("pre_grant_ready", 32'(req_argument_ready), 0);
    @(negedge clock);
    chk("grant_req2", 32'(grant), 32'h4);
    chk("busy_req2", 32'(busy), 1);
    run_txns(1'b0, 0);

    // Pointer should now be 3: req 3 beats req 0.
    set_arg(0, 16'h0A00); set_arg(3, 16'h0D03);
    unit_activation_data = 8'h11;
    expect_hs(KArg, 3, 16'h0D03); expect_hs(KAct, 3, 16'h0011);
    expect_hs(KArg, 0, 16'h0A00); expect_hs(KAct, 0, 16'h0011);
    req_argument_valid = 4'b1001;
    run_txns(1'b0, 0);

    // Training transaction on req 1.
    set_arg(1, 16'hFFF0);
    unit_activation_data = 8'h00;
    unit_delta_data = 16'h1234;
    train = 1'b1;
    expect_hs(KArg, 1, 16'hFFF0); expect_hs(KAct, 1, 16'h0000);
    expect_hs(KFbk, 1, 16'h1234); expect_hs(KDel, 1, 16'h1234);
    req_argument_valid = 4'b0010;
    run_txns(1'b0, 0);
    chk("train_idle_grant", 32'(grant), 0);

    // train drops during ACT: FBK/DEL still happen, next transaction is plain.
    set_arg(2, 16'h0777);
    unit_activation_data = 8'h33;
    unit_delta_data = 16'h5555;
    expect_hs(KArg, 2, 16'h0777); expect_hs(KAct, 2, 16'h0033);
    expect_hs(KFbk, 2, 16'hA002); expect_hs(KDel, 2, 16'h5555);
    req_argument_valid = 4'b0100;
    @(posedge clock); #1;
    @(posedge clock); #1 train = 1'b0;
    run_txns(1'b0, 0);
    set_arg(3, 16'h0333);
    expect_hs(KArg, 3, 16'h0333); expect_hs(KAct, 3, 16'h0033);
    req_argument_valid = 4'b1000;
    run_txns(1'b0, 0);

    // Backpressure: req 0 withholds activation_ready for 5 cycles.
    set_arg(0, 16'h0ABC);
    unit_activation_data = 8'h77;
    req_activation_ready = 4'b1110;
    expect_hs(KArg, 0, 16'h0ABC); expect_hs(KAct, 0, 16'h0077);
    req_argument_valid = 4'b0001;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_unit_ready", 32'(unit_activation_ready), 0);
      chk("bp_valid", 32'(req_activation_valid), 32'h1);
      chk("bp_data", 32'(req_activation_data), 32'h77);
      chk("bp_grant", 32'(grant), 32'h1);
    end
    @(posedge clock); #1 req_activation_ready = '1;
    run_txns(1'b0, 0);

    // Reset while parked in FBK.
    set_arg(1, 16'h0001);
    unit_activation_data = 8'h01;
    unit_feedback_ready = 1'b0;
    train = 1'b1;
    expect_hs(KArg, 1, 16'h0001); expect_hs(KAct, 1, 16'h0001);
    req_argument_valid = 4'b0010;
    repeat (3) begin @(posedge clock); #1; end
    chk("fbk_parked_grant", 32'(grant), 32'h2);
    chk("fbk_parked_valid", 32'(unit_feedback_valid), 1);
    reset = 1'b1; req_argument_valid = '0; train = 1'b0;
    @(negedge clock);
    chk("mid_reset_hs", all_hs(), 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("post_reset_grant", 32'(grant), 0);
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_hs", all_hs(), 0);
    chk("post_reset_queue", 32'(exp_q.size()), 0);
    unit_feedback_ready = 1'b1;
    set_arg(3, 16'h3333);
    unit_activation_data = 8'h99;
    expect_hs(KArg, 3, 16'h3333); expect_hs(KAct, 3, 16'h0099);
    @(posedge clock); #1 req_argument_valid = 4'b1000;
    run_txns(1'b0, 0);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule
